// File: rtl/pc_updater_if.sv
// Fetch-stage bundle between the PC updater and its surroundings:
// branch request, condition, flags and target in; PC out.
interface pc_updater_if;
   logic [15:0] InAddr;
   logic        branch;
   logic [2:0]  cond;
   logic        Z;
   logic        N;
   logic        V;
   logic [15:0] OutAddr;

   modport master (
      output InAddr, branch, cond, Z, N, V,
      input  OutAddr
   );

   modport slave (
      input  InAddr, branch, cond, Z, N, V,
      output OutAddr
   );
endinterface

// File: rtl/pc_updater.sv
// Program counter and next-PC select for the 16-bit fetch stage.
// Define PC_UPDATER_ALIGN_EN to force branch targets halfword-aligned.
module pc_updater (
   input logic         clk,
   input logic         rst,
   pc_updater_if.slave bus
);
   localparam logic [2:0] COND_NE = 3'b000;
   localparam logic [2:0] COND_EQ = 3'b001;
   localparam logic [2:0] COND_GT = 3'b010;
   localparam logic [2:0] COND_LT = 3'b011;
   localparam logic [2:0] COND_GE = 3'b100;
   localparam logic [2:0] COND_LE = 3'b101;
   localparam logic [2:0] COND_OV = 3'b110;

   logic [15:0] pc_q;
   logic [15:0] pc_d;
   logic [15:0] target;
   logic        cond_true;
   logic        taken;

   always_comb begin
      cond_true = 1'b1;
      case (bus.cond)
         COND_NE: cond_true = ~bus.Z;
         COND_EQ: cond_true = bus.Z;
         COND_GT: cond_true = ~bus.Z & ~bus.N;
         COND_LT: cond_true = bus.N;
         COND_GE: cond_true = bus.Z | ~bus.N;
         COND_LE: cond_true = bus.N | bus.Z;
         COND_OV: cond_true = bus.V;
         default: cond_true = 1'b1;
      endcase
   end

`ifdef PC_UPDATER_ALIGN_EN
   assign target = {bus.InAddr[15:1], 1'b0};
`else
   assign target = bus.InAddr;
`endif

   // Gate on branch first so unknown flags never reach the PC.
   always_comb begin
      taken = 1'b0;
      if (bus.branch == 1'b1) begin
         taken = cond_true;
      end
   end

   always_comb begin
      pc_d = pc_q + 16'd2;
      if (taken == 1'b1) begin
         pc_d = target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= 16'h0000;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign bus.OutAddr = pc_q;
endmodule

// File: tb/tb_pc_updater.sv
// Randomized scoreboard bench for pc_updater with a
// reference PC model; covers reset, conditions, wrap and alignment.
module tb_pc_updater;
   logic clk;
   logic rst;

   pc_updater_if bus ();

   pc_updater dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] exp_q [$];
   string       tag_q [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          pc_m     = 0;

   function automatic bit cond_ok(input bit [2:0] c,
                                  input bit z, input bit n,
                                  input bit v);
      case (c)
         3'd0:    return !z;
         3'd1:    return z;
         3'd2:    return !z && !n;
         3'd3:    return n;
         3'd4:    return z || !n;
         3'd5:    return n || z;
         3'd6:    return v;
         default: return 1'b1;
      endcase
   endfunction

   task automatic step(input bit r, input bit br,
                       input bit [2:0] c, input bit z,
                       input bit n, input bit v,
                       input bit [15:0] ia, input string tag);
      int tgt;
      @(negedge clk);
      rst        = r;
      bus.branch = br;
      bus.cond   = c;
      bus.Z      = z;
      bus.N      = n;
      bus.V      = v;
      bus.InAddr = ia;
`ifdef PC_UPDATER_ALIGN_EN
      tgt = int'(ia) - (int'(ia) % 2);
`else
      tgt = int'(ia);
`endif
      if (r)
         pc_m = 0;
      else if (br && cond_ok(c, z, n, v))
         pc_m = tgt;
      else
         pc_m = (pc_m + 2) % 65536;
      exp_q.push_back(16'(pc_m));
      tag_q.push_back(tag);
   endtask

   // Monitor: every registered PC update is checked against the model.
   initial begin
      logic [15:0] e;
      string       t;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_checks++;
            if (bus.OutAddr !== e) begin
               n_fail++;
               $display("FAIL %s: OutAddr=%h expected=%h",
                        t, bus.OutAddr, e);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wait_cyc;
      rst        = 1'b1;
      bus.branch = 1'b0;
      bus.cond   = 3'd0;
      bus.Z      = 1'b0;
      bus.N      = 1'b0;
      bus.V      = 1'b0;
      bus.InAddr = 16'h0000;

      step(1, 0, 0, 0, 0, 0, 16'h0000, "reset0");
      step(1, 0, 0, 0, 0, 0, 16'h0000, "reset1");
      step(0, 0, 0, 0, 0, 0, 16'h0000, "inc_first");
      step(0, 0, 0, 0, 0, 0, 16'h0000, "inc_second");

      step(0, 1, 3'b000, 0, 0, 0, 16'h0100, "ne_z0");
      step(0, 1, 3'b100, 0, 1, 0, 16'h0100, "ge_z0_n1");
      step(0, 1, 3'b110, 0, 0, 1, 16'h0100, "ov_v1");

      for (int c = 0; c < 8; c++) begin
         for (int f = 0; f < 8; f++) begin
            step(0, 1, 3'(c), f[2], f[1], f[0], 16'h0100,
                 $sformatf("sweep_c%0d_f%0d", c, f));
         end
      end

      step(0, 0, 3'b111, 1, 1, 1, 16'h0AAA, "no_branch");
      step(0, 0, 3'b111, 0, 0, 0, 16'h0AAA, "no_branch2");

      step(0, 1, 3'b111, 0, 0, 0, 16'hFFFE, "to_fffe");
      step(0, 0, 0, 0, 0, 0, 16'h0000, "wrap_fffe");
      step(0, 1, 3'b111, 0, 0, 0, 16'hFFFF, "to_ffff");
      step(0, 0, 0, 0, 0, 0, 16'h0000, "wrap_ffff");

      step(1, 1, 3'b111, 0, 0, 0, 16'h1234, "rst_prio");
      step(0, 0, 0, 0, 0, 0, 16'h0000, "after_rst");
      step(0, 1, 3'b111, 0, 0, 0, 16'h0101, "align");
      step(0, 0, 0, 0, 0, 0, 16'h0000, "align_inc");
      step(0, 1, 3'b111, 0, 0, 0, 16'h2000, "b2b_a");
      step(0, 1, 3'b111, 0, 0, 0, 16'h3000, "b2b_b");
      step(1, 0, 0, 0, 0, 0, 16'h0000, "mid_rst");
      step(0, 0, 0, 0, 0, 0, 16'h0000, "mid_rst_inc");

      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 31) == 0),
              1'($urandom), 3'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom),
              16'($urandom), "random");
      end

      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      #2;
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: pending=%0d expected=0",
                  exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
